// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program counter / fetch sequencer for the 8-bit core. A start handshake
//   selects one of three resident programs (multiply, string match, closest
//   pair). The PC then steps through the instruction ROM and applies relative
//   branches resolved by decode/ALU. A decoded halt stops the run. A cycle
//   watchdog aborts runs that never halt.
//
// Ports
//   clk_i          in   1      clock; all state updates on the rising edge
//   reset_i        in   1      synchronous active-high reset; wins over all inputs
//   start_i        in   1      start request (accepted in IDLE/DONE/TIMEOUT only)
//   prog_sel_i     in   2      program select: 0/1/2 valid, 3 ignored
//   halt_i         in   1      decoded halt for the instruction at pc_o
//   branch_i       in   1      decoded branch/branchb for the instruction at pc_o
//   branch_back_i  in   1      0 = forward branch, 1 = backward branch
//   cond_i         in   1      branch condition flag; the branch is taken when 1
//   offset_i       in   PC_W   unsigned branch distance
//   stall_i        in   1      hold the PC this cycle (multicycle load/store)
//   pc_o           out  PC_W   instruction ROM address
//   fetch_en_o     out  1      pc_o addresses a live instruction
//   busy_o         out  1      a run is in progress
//   done_o         out  1      last run ended on halt (held)
//   timeout_o      out  1      last run was aborted by the watchdog (held)
//   cycle_cnt_o    out  CNT_W  RUN cycles spent in the current/last run
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PC_W       = 8,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 93,
  parameter int PROG2_BASE = 145,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       prog_sel_i,
  input  logic             halt_i,
  input  logic             branch_i,
  input  logic             branch_back_i,
  input  logic             cond_i,
  input  logic [PC_W-1:0]  offset_i,
  input  logic             stall_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam logic [PC_W-1:0]  BASE0     = PC_W'(PROG0_BASE);
  localparam logic [PC_W-1:0]  BASE1     = PC_W'(PROG1_BASE);
  localparam logic [PC_W-1:0]  BASE2     = PC_W'(PROG2_BASE);
  // The counter value seen during the last RUN cycle that is allowed.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PC_W-1:0]   base_sel;

  always_comb begin
    case (prog_sel_i)
      2'd0:    base_sel = BASE0;
      2'd1:    base_sel = BASE1;
      default: base_sel = BASE2;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    cnt_nxt    = cnt;
    fetch_en_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    timeout_o  = 1'b0;
    case (state)
      S_RUN: begin
        fetch_en_o = 1'b1;
        busy_o     = 1'b1;
        // Stalled cycles still count toward the watchdog.
        cnt_nxt    = cnt + CNT_W'(1);
        // Priority order: watchdog, stall, halt, taken branch, sequential.
        if (cnt == WDOG_LAST) begin
          state_nxt = S_TIMEOUT;
        end else if (stall_i) begin
          pc_nxt = pc;
        end else if (halt_i) begin
          state_nxt = S_DONE;
        end else if (branch_i && cond_i) begin
          // Both branch directions are relative to the branch's own address.
          // Wrap-around modulo 2^PC_W is intended.
          pc_nxt = branch_back_i ? (pc - offset_i) : (pc + offset_i);
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      default: begin
        // IDLE, DONE and TIMEOUT all wait for a start request. A start with an
        // invalid selection leaves the state and the readout unchanged.
        done_o    = (state == S_DONE);
        timeout_o = (state == S_TIMEOUT);
        if (start_i && (prog_sel_i != 2'd3)) begin
          state_nxt = S_RUN;
          pc_nxt    = base_sel;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign pc_o        = pc;
  assign cycle_cnt_o = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic [1:0]       prog_sel_i;
  logic             halt_i;
  logic             branch_i;
  logic             branch_back_i;
  logic             cond_i;
  logic [PC_W-1:0]  offset_i;
  logic             stall_i;
  logic [PC_W-1:0]  pc_o;
  logic             fetch_en_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .PC_W(PC_W), .PROG0_BASE(0), .PROG1_BASE(93), .PROG2_BASE(145),
    .CNT_W(CNT_W), .MAX_CYCLES(20)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .prog_sel_i(prog_sel_i),
    .halt_i(halt_i), .branch_i(branch_i), .branch_back_i(branch_back_i),
    .cond_i(cond_i), .offset_i(offset_i), .stall_i(stall_i), .pc_o(pc_o),
    .fetch_en_o(fetch_en_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    start_i = 0; prog_sel_i = 0; halt_i = 0; branch_i = 0;
    branch_back_i = 0; cond_i = 0; offset_i = 0; stall_i = 0;
  endtask

  // Drive one decoded branch for the instruction currently on pc_o.
  task automatic br(input logic back, input logic c, input logic [PC_W-1:0] off);
    branch_i = 1; branch_back_i = back; cond_i = c; offset_i = off;
    tick();
    clear_in();
  endtask

  task automatic start_prog(input logic [1:0] sel);
    start_i = 1; prog_sel_i = sel;
    tick();
    clear_in();
  endtask

  initial begin
    clear_in();
    reset_i = 1;
    tick(); tick();
    reset_i = 0;
    chk("reset_pc", pc_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_fetch", fetch_en_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_cnt", cycle_cnt_o, 0);

    // Invalid program select in IDLE is ignored.
    start_prog(2'd3);
    chk("sel3_busy", busy_o, 0);
    chk("sel3_pc", pc_o, 0);

    // Program 1, sequential run, ignored start during RUN, halt at 97.
    start_prog(2'd1);
    chk("p1_pc93", pc_o, 93);
    chk("p1_busy", busy_o, 1);
    chk("p1_fetch", fetch_en_o, 1);
    chk("p1_cnt0", cycle_cnt_o, 0);
    tick();
    chk("p1_pc94", pc_o, 94);
    start_i = 1; prog_sel_i = 0;
    tick();
    clear_in();
    chk("run_start_ignored_pc", pc_o, 95);
    chk("run_start_ignored_cnt", cycle_cnt_o, 2);
    tick(); tick();
    chk("p1_pc97", pc_o, 97);
    halt_i = 1;
    tick();
    clear_in();
    chk("p1_done", done_o, 1);
    chk("p1_halt_pc", pc_o, 97);
    chk("p1_cnt5", cycle_cnt_o, 5);
    chk("p1_busy_off", busy_o, 0);
    tick();
    chk("done_hold_pc", pc_o, 97);
    chk("done_hold_cnt", cycle_cnt_o, 5);
    chk("done_hold_flag", done_o, 1);

    // Restart from DONE with program 0, then exercise branches and wrap.
    start_prog(2'd0);
    chk("restart_pc", pc_o, 0);
    chk("restart_done_clr", done_o, 0);
    chk("restart_cnt", cycle_cnt_o, 0);
    br(0, 1, 17);  chk("br_to17", pc_o, 17);
    br(0, 0, 7);   chk("br_nt_18", pc_o, 18);
    br(1, 1, 1);   chk("brb_to17", pc_o, 17);
    br(0, 1, 7);   chk("br_fwd24", pc_o, 24);
    br(0, 1, 23);  chk("br_to47", pc_o, 47);
    br(1, 1, 35);  chk("brb_47_12", pc_o, 12);
    br(0, 1, 238); chk("br_to250", pc_o, 250);
    br(0, 1, 10);  chk("br_wrap4", pc_o, 4);
    br(1, 1, 6);   chk("brb_wrap254", pc_o, 254);
    cond_i = 1;    // condition without branch has no effect
    tick();
    clear_in();
    chk("cond_only_seq", pc_o, 255);
    br(1, 0, 6);   chk("brb_nt_wrap0", pc_o, 0);
    chk("br_cnt11", cycle_cnt_o, 11);
    halt_i = 1;
    tick();
    clear_in();
    chk("halt0_done", done_o, 1);
    chk("halt0_pc", pc_o, 0);
    chk("halt0_cnt", cycle_cnt_o, 12);

    // Stall holds the PC over halt and branch; the counter keeps running.
    start_prog(2'd0);
    br(0, 1, 50);
    chk("stall_pc50", pc_o, 50);
    stall_i = 1; halt_i = 1; branch_i = 1; cond_i = 1; offset_i = 5;
    tick(); chk("stall1_pc", pc_o, 50);
    tick(); chk("stall2_pc", pc_o, 50);
    tick(); chk("stall3_pc", pc_o, 50);
    chk("stall_cnt", cycle_cnt_o, 4);
    chk("stall_busy", busy_o, 1);
    stall_i = 0; branch_i = 0; cond_i = 0; offset_i = 0;
    tick();
    clear_in();
    chk("stall_done", done_o, 1);
    chk("stall_done_pc", pc_o, 50);
    chk("stall_done_cnt", cycle_cnt_o, 5);

    // Reset in the middle of a run.
    start_prog(2'd0);
    br(0, 1, 40);
    chk("rst_pc40", pc_o, 40);
    reset_i = 1;
    tick();
    reset_i = 0;
    chk("midrst_pc", pc_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_cnt", cycle_cnt_o, 0);
    chk("midrst_done", done_o, 0);

    // Watchdog: program 2 never halts; MAX_CYCLES is 20.
    start_prog(2'd2);
    chk("p2_pc145", pc_o, 145);
    for (int i = 0; i < 19; i++) tick();
    chk("wd_pre_busy", busy_o, 1);
    chk("wd_pre_pc", pc_o, 164);
    chk("wd_pre_cnt", cycle_cnt_o, 19);
    halt_i = 1; stall_i = 1;  // watchdog outranks both
    tick();
    clear_in();
    chk("wd_timeout", timeout_o, 1);
    chk("wd_done", done_o, 0);
    chk("wd_busy", busy_o, 0);
    chk("wd_pc", pc_o, 164);
    chk("wd_cnt", cycle_cnt_o, 20);
    tick();
    chk("wd_hold_pc", pc_o, 164);
    chk("wd_hold_flag", timeout_o, 1);
    start_prog(2'd3);
    chk("wd_sel3_hold", timeout_o, 1);
    chk("wd_sel3_busy", busy_o, 0);
    start_prog(2'd1);
    chk("wd_restart_pc", pc_o, 93);
    chk("wd_restart_clr", timeout_o, 0);
    chk("wd_restart_busy", busy_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
